// File: rtl/john_count_pkg.sv
// Shared constants for the 4-bit Johnson counter: width, period and the legal code table.
// Codes are stored with bit i holding output n<i>.
package john_count_pkg;

    localparam int JC_WIDTH  = 4;
    localparam int JC_PERIOD = 8;

    typedef logic [JC_WIDTH-1:0] jc_state_t;

    // Legal codes in sequence order; read as n0n1n2n3 these are 0000, 1000, 1100, ..., 0001
    localparam jc_state_t JC_CODES [JC_PERIOD] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1111, 4'b1110, 4'b1100, 4'b1000
    };

    function automatic logic jc_is_legal(input jc_state_t s);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < JC_PERIOD; i++) begin
            if (s == JC_CODES[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/john_count_if.sv
// Bundle of the four Johnson counter phase outputs for observers of the counter.
// The counter drives through the master modport; consumers read through the slave modport.
interface john_count_if;
    logic n0;
    logic n1;
    logic n2;
    logic n3;

    modport master (output n0, n1, n2, n3);
    modport slave  (input  n0, n1, n2, n3);
endinterface

// File: rtl/john_count.sv
// Free-running 4-bit Johnson counter (period 8), asynchronous active-low reset.
// Optional JOHN_COUNT_SELF_CORRECT_EN sends any illegal code to 0000 on the next edge.
module john_count
    import john_count_pkg::*;
(
    output logic n0,
    output logic n1,
    output logic n2,
    output logic n3,
    input  logic clk,
    input  logic reset
);

    jc_state_t state_q;
    jc_state_t state_d;
    jc_state_t shift_d;

    // Twisted shift: bit 0 takes the inverted top bit, every other bit takes its lower neighbour
    assign shift_d[0] = ~state_q[JC_WIDTH-1];
    generate
        for (genvar gi = 1; gi < JC_WIDTH; gi++) begin : g_shift
            assign shift_d[gi] = state_q[gi-1];
        end
    endgenerate

    always_comb begin
        state_d = shift_d;
`ifdef JOHN_COUNT_SELF_CORRECT_EN
        if (!jc_is_legal(state_q)) begin
            state_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign n0 = state_q[0];
    assign n1 = state_q[1];
    assign n2 = state_q[2];
    assign n3 = state_q[3];

endmodule

// File: tb/tb_john_count.sv
// Self-checking bench for john_count: directed reset/sequence/illegal-state cases plus a
// randomized long run with reset pulses, checked against a phase-number reference model.
`timescale 1ns/1ps
module tb_john_count;
    import john_count_pkg::*;

    logic clk;
    logic reset;
    int   err_cnt;
    int   chk_cnt;
    int   phase;        // model: number of edges since last reset, mod 8

    john_count_if jc_if ();

    john_count dut (
        .n0    (jc_if.n0),
        .n1    (jc_if.n1),
        .n2    (jc_if.n2),
        .n3    (jc_if.n3),
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed state packed as written in the sequence table: {n0,n1,n2,n3}
    function automatic logic [3:0] obs_state();
        return {jc_if.n0, jc_if.n1, jc_if.n2, jc_if.n3};
    endfunction

    // After p edges from 0000, output n<i> is high exactly when i < p <= i+4
    function automatic logic [3:0] model_code(input int p);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[3-i] = (p > i) && (p <= i + 4);
        end
        return r;
    endfunction

    function automatic logic legal_obs(input logic [3:0] s);
        logic hit;
        jc_state_t c;
        hit = 1'b0;
        for (int i = 0; i < JC_PERIOD; i++) begin
            c = JC_CODES[i];
            if (s == {c[0], c[1], c[2], c[3]}) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        chk_cnt++;
        if (observed !== expected) begin
            err_cnt++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One rising edge; the model advances only when reset is released
    task automatic tick_check(input string tag);
        logic [3:0] prev;
        prev = obs_state();
        @(posedge clk);
        #1;
        if (reset) phase = (phase + 1) % JC_PERIOD;
        else       phase = 0;
        check_val(tag, obs_state(), model_code(phase));
        if (reset) check_val({tag, "_onebit"}, $countones(prev ^ obs_state()), 1);
        $display("tick %-10s n0n1n2n3=%b phase=%0d", tag, obs_state(), phase);
    endtask

    task automatic assert_reset_now(input string tag);
        reset = 1'b0;
        phase = 0;
        #1;
        check_val(tag, obs_state(), 4'b0000);
    endtask

    task automatic release_after_edge();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    localparam logic [3:0] PARASITIC [8] = '{
        4'b1010, 4'b1101, 4'b0110, 4'b1011, 4'b0101, 4'b0010, 4'b1001, 4'b0100
    };

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        err_cnt = 0;
        chk_cnt = 0;
        phase   = 0;
        reset   = 1'b1;

        // Reset asserted before any clock edge
        #1;
        assert_reset_now("rst_noclk");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_val("rst_hold", obs_state(), 4'b0000);
        end

        // Release 1 ns after an edge; nothing moves until the next edge
        release_after_edge();
        #3;
        check_val("rel_nochg", obs_state(), 4'b0000);
        for (int k = 0; k < 16; k++) tick_check("seq");

        // Async reset between edges at 1110
        while (phase != 3) tick_check("to_1110");
        check_val("at_1110", obs_state(), 4'b1110);
        @(negedge clk);
        assert_reset_now("rst_async");
        for (int k = 0; k < 2; k++) tick_check("rst_1110");
        release_after_edge();
        tick_check("rel_1110");

        // Mid-run reset at 0111 held for two clocks
        while (phase != 5) tick_check("to_0111");
        check_val("at_0111", obs_state(), 4'b0111);
        @(negedge clk);
        assert_reset_now("rst_mid");
        for (int k = 0; k < 2; k++) tick_check("rst_0111");
        release_after_edge();
        tick_check("rel_0111");
        check_val("rel_0111_v", obs_state(), 4'b1000);

        // Illegal state 0100 (only n1 high)
        @(negedge clk);
        force dut.state_q = 4'b0010;
        #1;
        release dut.state_q;
        #1;
        check_val("ill_load", obs_state(), 4'b0100);
`ifdef JOHN_COUNT_SELF_CORRECT_EN
        @(posedge clk); #1;
        check_val("ill_fix0", obs_state(), 4'b0000);
        $display("tick ill_fix0   n0n1n2n3=%b", obs_state());
        @(posedge clk); #1;
        check_val("ill_fix1", obs_state(), 4'b1000);
        $display("tick ill_fix1   n0n1n2n3=%b", obs_state());
`else
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check_val($sformatf("ill_loop%0d", k), obs_state(), PARASITIC[k]);
            $display("tick ill_loop%0d  n0n1n2n3=%b", k, obs_state());
        end
`endif
        @(negedge clk);
        assert_reset_now("rst_ill");
        release_after_edge();

        // Long randomized run with reset pulses
        for (int c = 0; c < 1000; c++) begin
            tick_check("run");
            check_val("run_legal", legal_obs(obs_state()), 1'b1);
            if ($urandom_range(0, 29) == 0) begin
                #($urandom_range(1, 3));
                assert_reset_now("run_rst");
                hold = $urandom_range(1, 3);
                for (int k = 0; k < hold; k++) tick_check("run_hold");
                release_after_edge();
                $display("tick run_rel    n0n1n2n3=%b after %0d held edges", obs_state(), hold);
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
